pulse_stretch_sched: RTL

- Schedules single-cycle event pulses from N requesters onto one shared stretched-pulse output channel, for fast-to-slow synchronous clock transfers.
- Each requester's events are counted, so none are lost while the channel is busy.
- A round-robin grant selects the next requester. The output is held high for a programmable length, tagged with the requester ID, then held low for a programmable gap.
- Sits between event sources (interrupt and status strobes) and a slow-domain consumer that samples `out`/`out_id`.

---
 rtl/pulse_stretch_sched_pkg.sv | 15 +
 rtl/pss_rr_arb.sv | 42 ++++
 rtl/pulse_stretch_sched.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/pulse_stretch_sched_pkg.sv
// Shared constants and FSM encoding for the pulse stretch scheduler.
package pulse_stretch_sched_pkg;

  localparam int N_DEF  = 4;
  localparam int IW_DEF = 2;
  localparam int CW_DEF = 4;
  localparam int LW_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PULSE = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

endpackage

// File: rtl/pss_rr_arb.sv
// Combinational round-robin arbiter: search starts at the requester after ptr.
module pss_rr_arb
  import pulse_stretch_sched_pkg::*;
#(
  parameter int N  = N_DEF,
  parameter int IW = IW_DEF
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_id,
  output logic          valid
);

  localparam logic [IW-1:0] LAST_ID = IW'(N - 1);
  localparam logic [IW:0]   N_W     = (IW + 1)'(N);

  logic [IW-1:0]  start;
  logic [2*N-1:0] dbl_shift;
  logic [N-1:0]   rot;
  logic [IW-1:0]  off;
  logic [IW:0]    sum;

  assign start = (ptr == LAST_ID) ? '0 : ptr + 1'b1;

  // Doubling the vector turns the wrap-around rotate into a plain shift.
  assign dbl_shift = {req, req} >> start;
  assign rot       = dbl_shift[N-1:0];

  always_comb begin
    off = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (rot[k]) off = IW'(k);
    end
  end

  assign sum    = {1'b0, start} + {1'b0, off};
  assign gnt_id = (sum >= N_W) ? IW'(sum - N_W) : sum[IW-1:0];
  assign valid  = |req;
  assign gnt    = valid ? (N'(1) << gnt_id) : '0;

endmodule

// File: rtl/pulse_stretch_sched.sv
// Shares one stretched-pulse channel among N counted event requesters.
// Define PULSE_STRETCH_SCHED_COALESCE_EN to replace counters with 1-bit pending flags.
module pulse_stretch_sched
  import pulse_stretch_sched_pkg::*;
#(
  parameter int N  = N_DEF,
  parameter int IW = IW_DEF,
  parameter int CW = CW_DEF,
  parameter int LW = LW_DEF
) (
  input  logic          clk,
  input  logic          nreset,
  input  logic          en,
  input  logic [LW-1:0] cfg_len,
  input  logic [LW-1:0] cfg_gap,
  input  logic [N-1:0]  in_pulse,
  input  logic          ovf_clear,
  output logic          out,
  output logic [IW-1:0] out_id,
  output logic          busy,
  output logic [N-1:0]  pending,
  output logic [N-1:0]  overflow
);

  state_t        state_reg, state_next;
  logic [LW-1:0] tmr_reg, tmr_next;
  logic [LW-1:0] gap_reg, gap_next;
  logic [IW-1:0] id_reg, id_next;
  logic [IW-1:0] ptr_reg, ptr_next;

  logic [N-1:0]  gnt;
  logic [IW-1:0] gnt_id;
  logic          gnt_valid;
  logic          grant;

  pss_rr_arb #(
    .N  (N),
    .IW (IW)
  ) u_arb (
    .req    (pending),
    .ptr    (ptr_reg),
    .gnt    (gnt),
    .gnt_id (gnt_id),
    .valid  (gnt_valid)
  );

  always_comb begin
    state_next = state_reg;
    tmr_next   = tmr_reg;
    gap_next   = gap_reg;
    id_next    = id_reg;
    ptr_next   = ptr_reg;
    grant      = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (en && gnt_valid) begin
          grant      = 1'b1;
          id_next    = gnt_id;
          ptr_next   = gnt_id;
          tmr_next   = cfg_len;
          gap_next   = cfg_gap;
          state_next = ST_PULSE;
        end
      end
      ST_PULSE: begin
        // The same down-counter is reloaded with the latched gap on exit.
        if (tmr_reg == '0) begin
          tmr_next   = gap_reg;
          state_next = ST_GAP;
        end else begin
          tmr_next = tmr_reg - 1'b1;
        end
      end
      ST_GAP: begin
        if (tmr_reg == '0) begin
          state_next = ST_IDLE;
        end else begin
          tmr_next = tmr_reg - 1'b1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nreset) begin
      state_reg <= ST_IDLE;
      tmr_reg   <= '0;
      gap_reg   <= '0;
      id_reg    <= '0;
      ptr_reg   <= IW'(N - 1);
    end else begin
      state_reg <= state_next;
      tmr_reg   <= tmr_next;
      gap_reg   <= gap_next;
      id_reg    <= id_next;
      ptr_reg   <= ptr_next;
    end
  end

  assign out    = (state_reg == ST_PULSE);
  assign busy   = (state_reg == ST_PULSE) || (state_reg == ST_GAP);
  assign out_id = id_reg;

`ifdef PULSE_STRETCH_SCHED_COALESCE_EN
  logic unused_ovf_clear;
  assign unused_ovf_clear = ovf_clear;
`endif

  for (genvar gi = 0; gi < N; gi++) begin : g_req
    logic inc;
    logic dec;
    assign inc = in_pulse[gi];
    assign dec = grant & gnt[gi];

`ifdef PULSE_STRETCH_SCHED_COALESCE_EN
    logic flag_reg;

    // An event on the grant cycle arrives after the grant, so it keeps the flag set.
    always_ff @(posedge clk) begin
      if (!nreset) begin
        flag_reg <= 1'b0;
      end else if (inc) begin
        flag_reg <= 1'b1;
      end else if (dec) begin
        flag_reg <= 1'b0;
      end
    end

    assign pending[gi]  = flag_reg;
    assign overflow[gi] = 1'b0;
`else
    logic [CW-1:0] cnt_reg;
    logic          ovf_reg;
    logic          sat;

    assign sat = &cnt_reg;

    always_ff @(posedge clk) begin
      if (!nreset) begin
        cnt_reg <= '0;
        ovf_reg <= 1'b0;
      end else begin
        if (inc && !dec && !sat) begin
          cnt_reg <= cnt_reg + 1'b1;
        end else if (dec && !inc) begin
          cnt_reg <= cnt_reg - 1'b1;
        end
        // A fresh overflow takes precedence over a same-cycle clear.
        if (inc && !dec && sat) begin
          ovf_reg <= 1'b1;
        end else if (ovf_clear) begin
          ovf_reg <= 1'b0;
        end
      end
    end

    assign pending[gi]  = |cnt_reg;
    assign overflow[gi] = ovf_reg;
`endif
  end

endmodule
